dbg_responder: RTL and testbench

DBG_RESPONDER -- requirements
Module: dbg_responder

---
 rtl/dbg_pkg.sv | 24 ++
 rtl/dbg_intf.sv | 27 ++
 rtl/dbg_responder.sv | 147 ++++++++++++++
 tb/tb_dbg_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Debug responder shared definitions: command codes, FSM states,
// response words. Used by both responder and initiator side.
package dbg_pkg;

  localparam logic [7:0] CMD_NONE   = 8'h00;
  localparam logic [7:0] CMD_HALT   = 8'h01;
  localparam logic [7:0] CMD_RESUME = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h04;

  typedef enum logic [2:0] {
    IDLE,
    HALT_WAIT,
    RD,
    WR,
    DONE,
    WAIT_CLR
  } state_e;

  localparam logic [31:0] DEAD_BEEF    = 32'hDEAD_BEEF;
  localparam logic [7:0]  HALT_TIMEOUT = 8'd255;
  localparam logic [31:0] TIMEOUT_ERR  = 32'hFFFF_FFFF;

endpackage

// File: rtl/dbg_intf.sv
// Debug bus between initiator and responder.
// cmd/addr/data_dbg_dut flow in, data_dut_dbg/dut_done flow back.
interface dbg_intf;

  logic [7:0]  cmd;
  logic [31:0] addr;
  logic [31:0] data_dbg_dut;
  logic [31:0] data_dut_dbg;
  logic        dut_done;

  modport dut (
    input  cmd,
    input  addr,
    input  data_dbg_dut,
    output data_dut_dbg,
    output dut_done
  );

  modport host (
    output cmd,
    output addr,
    output data_dbg_dut,
    input  data_dut_dbg,
    input  dut_done
  );

endinterface

// File: rtl/dbg_responder.sv
// Debug command responder: halt/resume the core, debug RF access.
// Optional halt timeout enabled by defining DBG_HALT_TIMEOUT_EN.
import dbg_pkg::*;

module dbg_responder (
  input  logic        clk,
  input  logic        rstn_i,
  dbg_intf.dut        dbg_bus,
  input  logic        core_idle_i,
  output logic        halt_o,
  output logic [4:0]  rf_raddr_o,
  input  logic [31:0] rf_rdata_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        halted_o
);

  state_e      state_q, state_d;
  logic        halt_q, halt_d;
  logic        halted_q, halted_d;
  logic        we_q, we_d;
  logic [4:0]  raddr_q, raddr_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
`ifdef DBG_HALT_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
`endif

  logic [7:0] cmd;
  logic [4:0] reg_idx;

  assign cmd     = dbg_bus.cmd;
  assign reg_idx = dbg_bus.addr[4:0];

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      halt_q   <= 1'b0;
      halted_q <= 1'b0;
      we_q     <= 1'b0;
      raddr_q  <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifdef DBG_HALT_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      halt_q   <= halt_d;
      halted_q <= halted_d;
      we_q     <= we_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
`ifdef DBG_HALT_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    halt_d   = halt_q;
    halted_d = halted_q;
    we_d     = 1'b0;
    raddr_d  = raddr_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
`ifdef DBG_HALT_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          (cmd == CMD_NONE): ;
          (cmd == CMD_HALT): begin
            halt_d = 1'b1;
            if (halted_q) begin
              state_d = DONE;
            end else begin
              state_d = HALT_WAIT;
`ifdef DBG_HALT_TIMEOUT_EN
              cnt_d   = '0;
`endif
            end
          end
          (cmd == CMD_RESUME): begin
            state_d  = DONE;
            halt_d   = 1'b0;
            halted_d = 1'b0;
          end
          (cmd == CMD_READ): begin
            state_d = RD;
            if (halted_q) raddr_d = reg_idx;
          end
          (cmd == CMD_WRITE): begin
            state_d = WR;
            // x0 is hardwired; a write to it completes silently
            if (halted_q && reg_idx != 5'd0) begin
              we_d    = 1'b1;
              waddr_d = reg_idx;
              wdata_d = dbg_bus.data_dbg_dut;
            end
          end
          default: state_d = DONE;
        endcase
      end
      HALT_WAIT: begin
        if (core_idle_i) begin
          state_d  = DONE;
          halted_d = 1'b1;
        end
`ifdef DBG_HALT_TIMEOUT_EN
        else if (cnt_q == HALT_TIMEOUT - 8'd1) begin
          state_d = DONE;
          rdata_d = TIMEOUT_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      RD: begin
        state_d = DONE;
        rdata_d = halted_q ? rf_rdata_i : DEAD_BEEF;
      end
      WR:       state_d = DONE;
      DONE:     state_d = WAIT_CLR;
      WAIT_CLR: if (cmd == CMD_NONE) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign dbg_bus.dut_done     = (state_q == DONE);
  assign dbg_bus.data_dut_dbg = rdata_q;
  assign halt_o               = halt_q;
  assign halted_o             = halted_q;
  assign rf_we_o              = we_q;
  assign rf_raddr_o           = raddr_q;
  assign rf_waddr_o           = waddr_q;
  assign rf_wdata_o           = wdata_q;

endmodule

// File: tb/tb_dbg_responder.sv
// Bench for dbg_responder: directed scenarios then random commands
// scored against a transaction-level model of the debug protocol.
module tb_dbg_responder;
  import dbg_pkg::*;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        core_idle_i = 1'b0;
  logic        halt_o, halted_o, rf_we_o;
  logic [4:0]  rf_raddr_o, rf_waddr_o;
  logic [31:0] rf_rdata_i, rf_wdata_o;

  always #5 clk = ~clk;

  dbg_intf bus ();

  dbg_responder dut (
    .clk         (clk),
    .rstn_i      (rstn_i),
    .dbg_bus     (bus),
    .core_idle_i (core_idle_i),
    .halt_o      (halt_o),
    .rf_raddr_o  (rf_raddr_o),
    .rf_rdata_i  (rf_rdata_i),
    .rf_we_o     (rf_we_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o),
    .halted_o    (halted_o)
  );

  // core register file seen by the responder
  logic [31:0] rf_mem [32];
  int          we_total;
  logic [4:0]  last_waddr;
  logic [31:0] last_wdata;

  always @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h0;
      we_total   <= 0;
      last_waddr <= 5'h0;
      last_wdata <= 32'h0;
    end else if (rf_we_o) begin
      rf_mem[rf_waddr_o] <= rf_wdata_o;
      we_total           <= we_total + 1;
      last_waddr         <= rf_waddr_o;
      last_wdata         <= rf_wdata_o;
    end
  end

  assign rf_rdata_i = rf_mem[rf_raddr_o];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_rf [32];
  bit          m_halt, m_halted;
  logic [31:0] m_data;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_halt   = 1'b0;
    m_halted = 1'b0;
    m_data   = 32'h0;
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'h0;
  endtask

  task automatic run_cmd(input logic [7:0] c, input logic [31:0] a,
                         input logic [31:0] d, input int dly,
                         output int lat, output int extra, output int wes);
    int w0;
    @(negedge clk);
    bus.cmd = c;
    bus.addr = a;
    bus.data_dbg_dut = d;
    core_idle_i = (dly == 0);
    w0 = we_total;
    lat = -1;
    extra = 0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      core_idle_i = (k >= dly);
      if (bus.dut_done) begin
        lat = k;
        break;
      end
    end
    core_idle_i = 1'b1;
    // command stays asserted: must not be executed again
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.dut_done) extra++;
    end
    @(negedge clk);
    bus.cmd = CMD_NONE;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.dut_done) extra++;
    end
    wes = we_total - w0;
  endtask

  task automatic apply(input logic [7:0] c, input logic [31:0] a,
                       input logic [31:0] d, input int dly);
    int exp_lat, exp_we, lat, extra, wes;
    logic [4:0] idx;
    idx = a[4:0];
    exp_we = 0;
    exp_lat = 1;
    if (c == CMD_HALT) begin
      if (!m_halted) begin
        if (dly >= 256) begin
          exp_lat = 256;
          m_data = 32'hFFFF_FFFF;
        end else begin
          exp_lat = (dly < 1 ? 1 : dly) + 1;
          m_halted = 1'b1;
        end
      end
      m_halt = 1'b1;
    end else if (c == CMD_RESUME) begin
      m_halt = 1'b0;
      m_halted = 1'b0;
    end else if (c == CMD_READ) begin
      exp_lat = 2;
      m_data = m_halted ? exp_rf[idx] : 32'hDEAD_BEEF;
    end else if (c == CMD_WRITE) begin
      exp_lat = 2;
      if (m_halted && idx != 5'd0) begin
        exp_we = 1;
        exp_rf[idx] = d;
      end
    end
    run_cmd(c, a, d, dly, lat, extra, wes);
    check($sformatf("latency cmd%0h", c), lat, exp_lat);
    check($sformatf("repeat_done cmd%0h", c), extra, 0);
    check($sformatf("we_pulses cmd%0h", c), wes, exp_we);
    if (exp_we == 1) begin
      check("waddr", 32'(last_waddr), 32'(idx));
      check("wdata", last_wdata, d);
    end
    check($sformatf("halt_o cmd%0h", c), 32'(halt_o), 32'(m_halt));
    check($sformatf("halted_o cmd%0h", c), 32'(halted_o), 32'(m_halted));
    check($sformatf("data cmd%0h", c), bus.data_dut_dbg, m_data);
  endtask

  initial begin
    logic [7:0] c;
    int r;
    bus.cmd = CMD_NONE;
    bus.addr = 32'h0;
    bus.data_dbg_dut = 32'h0;
    model_reset();
    #12;
    check("rst halt_o", 32'(halt_o), 32'h0);
    check("rst halted_o", 32'(halted_o), 32'h0);
    check("rst dut_done", 32'(bus.dut_done), 32'h0);
    check("rst rf_we_o", 32'(rf_we_o), 32'h0);
    check("rst data", bus.data_dut_dbg, 32'h0);
    check("rst raddr", 32'(rf_raddr_o), 32'h0);
    check("rst waddr", 32'(rf_waddr_o), 32'h0);
    check("rst wdata", rf_wdata_o, 32'h0);
    @(negedge clk);
    rstn_i = 1'b1;

    // idle with no command: nothing completes
    repeat (4) begin
      @(posedge clk); #1;
      check("idle no done", 32'(bus.dut_done), 32'h0);
    end

    apply(CMD_HALT, 32'h0, 32'h0, 5);
    apply(CMD_WRITE, 32'hABCD_EF07, 32'h1234_5678, 0);
    apply(CMD_READ, 32'h0000_0007, 32'h0, 0);
    check("x7 readback", bus.data_dut_dbg, 32'h1234_5678);
    apply(CMD_WRITE, 32'h0000_0000, 32'hFFFF_FFFF, 0);
    apply(CMD_READ, 32'hFFFF_FFE0, 32'h0, 0);
    apply(CMD_HALT, 32'h0, 32'h0, 0);
    apply(CMD_RESUME, 32'h0, 32'h0, 0);
    apply(CMD_READ, 32'h0000_0003, 32'h0, 0);
    check("not halted read", bus.data_dut_dbg, 32'hDEAD_BEEF);
    apply(CMD_WRITE, 32'h0000_0009, 32'h5555_AAAA, 0);
    apply(8'h7F, 32'h0, 32'h0, 0);

    // reset in the middle of a halt wait
    @(negedge clk);
    bus.cmd = CMD_HALT;
    core_idle_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rstn_i = 1'b0;
    #1;
    check("midrst halt_o", 32'(halt_o), 32'h0);
    check("midrst dut_done", 32'(bus.dut_done), 32'h0);
    check("midrst state", 32'(dut.state_q), 32'(IDLE));
    bus.cmd = CMD_NONE;
    model_reset();
    @(negedge clk);
    rstn_i = 1'b1;
    core_idle_i = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("postrst no done", 32'(bus.dut_done), 32'h0);
    end

`ifdef DBG_HALT_TIMEOUT_EN
    apply(CMD_HALT, 32'h0, 32'h0, 1000);
    check("timeout data", bus.data_dut_dbg, 32'hFFFF_FFFF);
    apply(CMD_RESUME, 32'h0, 32'h0, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2) c = CMD_HALT;
      else if (r == 2) c = CMD_RESUME;
      else if (r < 6) c = CMD_READ;
      else if (r < 9) c = CMD_WRITE;
      else c = 8'(8'h05 + $urandom_range(0, 250));
      apply(c, $urandom(), $urandom(), $urandom_range(0, 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
